// File: rtl/mult_arbiter.sv
// mult_arbiter: four requesters share one 8x8 Wallace-tree multiplier through a
// two-stage valid/ready pipeline. Arbitration is round-robin or fixed priority.

// 3:2 carry-save compressor over 16-bit rows; carries out of bit 15 are
// dropped because the final product always fits in 16 bits.
module csa16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    output logic [15:0] sum,
    output logic [15:0] carry
);
    assign sum   = x ^ y ^ z;
    assign carry = {(x[14:0] & y[14:0]) | (x[14:0] & z[14:0]) | (y[14:0] & z[14:0]), 1'b0};
endmodule

// Gate-level 8x8 unsigned Wallace multiplier: AND-array partial products,
// four carry-save layers (8 -> 6 -> 4 -> 3 -> 2 rows), ripple-carry final add.
module wallace_multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] pp [8];
    logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
    logic [15:0] cy;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_pp
            assign pp[i] = {8'b0, a & {8{b[i]}}} << i;
        end
    endgenerate

    // layer 1
    csa16 u_l1a (.x(pp[0]), .y(pp[1]), .z(pp[2]), .sum(s0), .carry(c0));
    csa16 u_l1b (.x(pp[3]), .y(pp[4]), .z(pp[5]), .sum(s1), .carry(c1));
    // layer 2
    csa16 u_l2a (.x(s0), .y(c0), .z(s1), .sum(s2), .carry(c2));
    csa16 u_l2b (.x(c1), .y(pp[6]), .z(pp[7]), .sum(s3), .carry(c3));
    // layer 3
    csa16 u_l3 (.x(s2), .y(c2), .z(s3), .sum(s4), .carry(c4));
    // layer 4
    csa16 u_l4 (.x(s4), .y(c4), .z(c3), .sum(s5), .carry(c5));

    // final carry-propagate adder
    assign cy[0] = 1'b0;
    generate
        for (i = 0; i < 16; i++) begin : g_rca
            assign p[i] = s5[i] ^ c5[i] ^ cy[i];
            if (i < 15) begin : g_cy
                assign cy[i+1] = (s5[i] & c5[i]) | (cy[i] & (s5[i] ^ c5[i]));
            end
        end
    endgenerate
endmodule

// Top: arbiter + stage 1 (operands) + shared multiplier + stage 2 (result).
module mult_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [3:0]  req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_product,
    output logic [1:0]  rsp_id,
    output logic [1:0]  inflight
);
    logic        s1_valid;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [1:0]  s1_id;
    logic [1:0]  rr_ptr;
    logic [15:0] product;
    logic        adv1;
    logic        adv2;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        grant_any;
    logic [1:0]  idx;

    // A stage may advance when it is empty or the stage after it advances.
    assign adv2 = !rsp_valid | rsp_ready;
    assign adv1 = !s1_valid | adv2;

    // Arbitration: search from rr_ptr (round-robin) or from 0 (fixed priority).
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_any = 1'b0;
        grant_id  = 2'd0;
        idx       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = RR_EN ? rr_ptr + 2'(k) : 2'(k);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        grant = grant_any ? (4'b0001 << grant_id) : 4'b0000;
    end

    // Readiness is suppressed during reset so nothing is accepted while held.
    assign req_ready = (rst_n && adv1) ? grant : 4'b0000;

    // Stage 1: capture the granted operands and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            s1_valid <= 1'b0;
            op_a     <= 8'd0;
            op_b     <= 8'd0;
            s1_id    <= 2'd0;
            rr_ptr   <= 2'd0;
        end else if (adv1) begin
            s1_valid <= grant_any;
            if (grant_any) begin
                op_a   <= req_a[8*grant_id +: 8];
                op_b   <= req_b[8*grant_id +: 8];
                s1_id  <= grant_id;
                rr_ptr <= grant_id + 2'd1;
            end
        end
    end

    wallace_multiplier u_mul (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    // Stage 2: register the product; held stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_product <= 16'd0;
            rsp_id      <= 2'd0;
        end else if (adv2) begin
            rsp_valid   <= s1_valid;
            rsp_product <= product;
            rsp_id      <= s1_id;
        end
    end

    assign inflight = {1'b0, s1_valid} + {1'b0, rsp_valid};
endmodule
